// File: rtl/traffic_pkg.sv
// Shared constants for the traffic-signal controller: timer width and the
// phase durations (cycle counts at a 10 MHz clock).
package traffic_pkg;

  localparam int unsigned TIMER_NBITS = 32;

  localparam logic [31:0] T_3S  = 32'h01C9_C380;
  localparam logic [31:0] T_6S  = 32'h0393_8700;
  localparam logic [31:0] T_10S = 32'h05F5_E100;
  localparam logic [31:0] T_INI = 32'd0;

endpackage

// File: rtl/traffic_timer.sv
// Programmable interval timer. Counts from cnt_ini up to cnt_rst and raises
// a registered terminal flag. Build option TRAFFIC_TIMER_STICKY_EN makes the
// flag sticky (count holds, flag stays high until reset) instead of a
// one-cycle pulse with auto-reload.
module traffic_timer
  import traffic_pkg::*;
#(
  parameter int unsigned NBITS = TIMER_NBITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NBITS-1:0] cnt_ini,
  input  logic [NBITS-1:0] cnt_rst,
  output logic             timer
);

  logic [NBITS-1:0] cnt_q, cnt_d;
  logic             timer_q, timer_d;

  // Next-state: compare with >= so lowering cnt_rst below the current count
  // still terminates on the next edge; the count never passes cnt_rst, so it
  // cannot wrap.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    cnt_d   = cnt_q;
    timer_d = timer_q;
`ifdef TRAFFIC_TIMER_STICKY_EN
    if (timer_q) begin
      // Terminal count already reached: hold everything until reset.
      cnt_d   = cnt_q;
      timer_d = 1'b1;
    end else if (cnt_q >= cnt_rst) begin
      timer_d = 1'b1;
    end else begin
      cnt_d   = cnt_q + NBITS'(1);
      timer_d = 1'b0;
    end
`else
    if (cnt_q >= cnt_rst) begin
      timer_d = 1'b1;
      cnt_d   = cnt_ini;
    end else begin
      cnt_d   = cnt_q + NBITS'(1);
      timer_d = 1'b0;
    end
`endif
  end

  // State registers; reset loads the start value and clears the flag at once.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values; the async load value is a live input, so
    // cnt tracks cnt_ini for as long as reset is held.
    if (reset) begin
      cnt_q   <= cnt_ini;
      timer_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
    end
  end

  assign timer = timer_q;

endmodule

// File: tb/tb_traffic_timer.sv
// Self-checking bench for traffic_timer (NBITS=8). The reference model tracks
// the value loaded at the last (re)load plus the number of edges since then,
// and applies the terminal rule to that sum. Honours TRAFFIC_TIMER_STICKY_EN.
module tb_traffic_timer;

  localparam int unsigned NBITS = 8;

  logic             clk;
  logic             reset;
  logic [NBITS-1:0] cnt_ini;
  logic [NBITS-1:0] cnt_rst;
  logic             timer;

  int total;
  int bad;

  // Reference model state
  longint base;      // value loaded at last reset / reload
  longint elapsed;   // edges since that load
  bit     hit;       // sticky flag reached (sticky build only)
  bit     exp_timer;

  traffic_timer #(.NBITS(NBITS)) dut (
    .clk     (clk),
    .reset   (reset),
    .cnt_ini (cnt_ini),
    .cnt_rst (cnt_rst),
    .timer   (timer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance model by one rising edge using the inputs present before it.
  task automatic model_edge();
    longint cur;
`ifdef TRAFFIC_TIMER_STICKY_EN
    if (hit) begin
      exp_timer = 1'b1;
    end else begin
      cur = base + elapsed;
      if (cur >= longint'(cnt_rst)) begin
        hit       = 1'b1;
        exp_timer = 1'b1;
      end else begin
        elapsed   = elapsed + 1;
        exp_timer = 1'b0;
      end
    end
`else
    cur = base + elapsed;
    if (cur >= longint'(cnt_rst)) begin
      exp_timer = 1'b1;
      base      = longint'(cnt_ini);
      elapsed   = 0;
    end else begin
      elapsed   = elapsed + 1;
      exp_timer = 1'b0;
    end
`endif
  endtask

  // One clock edge plus a comparison 1 ns later.
  task automatic tick(input string name);
    model_edge();
    @(posedge clk);
    #1;
    total++;
    if (timer !== exp_timer) begin
      bad++;
      $display("FAIL %s t=%0t: timer=%b expected=%b (ini=%0d rst=%0d)",
               name, $time, timer, exp_timer, cnt_ini, cnt_rst);
    end
  endtask

  // Asynchronous reset pulse between edges; timer must clear with no edge.
  task automatic pulse_reset(input string name);
    reset = 1'b1;
    #2;
    total++;
    if (timer !== 1'b0) begin
      bad++;
      $display("FAIL %s_async_clear t=%0t: timer=%b expected=0", name, $time, timer);
    end
    reset   = 1'b0;
    base    = longint'(cnt_ini);
    elapsed = 0;
    hit     = 1'b0;
    #1;
  endtask

  task automatic run(input string name, input int n);
    for (int i = 0; i < n; i++) tick(name);
  endtask

  task automatic test_reset();
    cnt_ini = 8'd5;
    cnt_rst = 8'd7;
    pulse_reset("reset_init");
    run("reset_count", 2);       // mid-count
    pulse_reset("reset_midcount");
    // Reload to 5 is visible as pulse after 3 edges (7-5+1)
    run("reset_reload", 8);
  endtask

  task automatic test_basic();
    cnt_ini = 8'd0;
    cnt_rst = 8'd10;
    pulse_reset("basic");
    run("basic", 10);
    // The 11th edge must raise timer directly, independent of the model
    @(posedge clk);
    #1;
    model_edge();
    total++;
    if (timer !== 1'b1) begin
      bad++;
      $display("FAIL basic_edge11: timer=%b expected=1", timer);
    end
    run("basic", 25);
  endtask

  task automatic test_nonzero_start();
    cnt_ini = 8'd3;
    cnt_rst = 8'd7;
    pulse_reset("nonzero");
    run("nonzero", 16);
  endtask

  task automatic test_degenerate();
    cnt_ini = 8'd4;
    cnt_rst = 8'd4;
    pulse_reset("equal");
    run("equal", 6);
    cnt_ini = 8'd9;
    cnt_rst = 8'd2;
    pulse_reset("stuck");
    run("stuck", 8);
    pulse_reset("stuck_clear");
  endtask

  task automatic test_mid_change();
    cnt_ini = 8'd0;
    cnt_rst = 8'd100;
    pulse_reset("midchg");
    run("midchg_count", 50);
    cnt_rst = 8'd20;
    run("midchg_term", 1);
    run("midchg_after", 25);
  endtask

  task automatic test_boundary_max();
    cnt_ini = 8'd250;
    cnt_rst = 8'd255;
    pulse_reset("maxrst");
    run("maxrst", 14);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) cnt_ini = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 15) == 0) cnt_rst = 8'($urandom_range(0, 24));
      if ($urandom_range(0, 39) == 0) pulse_reset("rand");
      tick("rand");
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    base      = 0;
    elapsed   = 0;
    hit       = 1'b0;
    exp_timer = 1'b0;
    reset     = 1'b1;
    cnt_ini   = '0;
    cnt_rst   = 8'd10;
    #13;
    total++;
    if (timer !== 1'b0) begin
      bad++;
      $display("FAIL por_timer: timer=%b expected=0", timer);
    end
    reset = 1'b0;
    #1;

    test_reset();
    test_basic();
    test_nonzero_start();
    test_degenerate();
    test_mid_change();
    test_boundary_max();
    test_random();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_timer.md
Name: traffic_timer

Overview:
- Programmable interval timer for the traffic-signal controller FSM.
- Counts clock cycles from a loadable start value (cnt_ini) up to a terminal value (cnt_rst), then raises `timer` for one cycle.
- The controller pulses `reset` at the start of every light phase, sets cnt_rst to select the phase length, and waits for `timer` before leaving the phase.

Parameters:
- NBITS, 32, width of the counter and of both count-value inputs.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- reset  input  1  asynchronous, active-high; loads the counter and clears `timer`.
- cnt_ini  input  NBITS  start value loaded on reset and on every reload.
- cnt_rst  input  NBITS  terminal count value; sampled every cycle, unsigned.
- timer  output  1  registered terminal-count flag.

Behaviour:
- Internal state: register `cnt` [NBITS-1:0] and register `timer`. No other state.
- Reset (asynchronous, active-high):
  - cnt <= cnt_ini; timer <= 0.
  - Held for as long as reset is high.
  - Applies immediately, including mid-count.
- Each rising clk edge with reset low:
  - If cnt >= cnt_rst (unsigned): timer <= 1 and cnt <= cnt_ini (auto-reload).
  - Else: cnt <= cnt + 1 and timer <= 0.
- Latency: with cnt_ini = 0 and cnt_rst = N, after reset release:
  - cnt reaches N at rising edge N.
  - timer is 1 after edge N+1, for exactly one cycle.
  - Period is N+1 cycles, repeating while reset stays low.
  - General period is (cnt_rst - cnt_ini + 1) cycles.
- The >= compare, not ==, guarantees termination if cnt_rst is lowered mid-count below the current cnt: terminal on the next edge.
- cnt_rst < cnt_ini: terminal condition is true every edge, so timer stays 1 continuously until reset.
- cnt_rst == cnt_ini: timer pulses every cycle (1,1,1…), because each reload already satisfies the compare.
- Wrap-around: cnt never increments past cnt_rst, so no overflow occurs for any cnt_rst ≤ 2^NBITS-1.
- cnt_ini and cnt_rst changes while counting take effect at the next edge; no input is latched.
- timer is purely registered; it has no combinational path from any input.

Optional Feature:
- Macro: TRAFFIC_TIMER_STICKY_EN.
- Defined (sticky mode):
  - On terminal count, timer <= 1 and cnt holds its value, with no reload.
  - timer remains 1 until reset is asserted.
- Undefined (default): one-cycle pulse with auto-reload, as specified above.
- Reset behaviour is identical in both modes.

Decomposition:
- Shared package traffic_pkg:
  - TIMER_NBITS = 32.
  - Phase-duration constants: T_3S = 32'h01C9C380, T_6S = 32'h03938700, T_10S = 32'h05F5E100 (cycle counts at a 10 MHz clock).
  - T_INI = 0.
- No sub-module; a single always block for the counter and flag is natural.

Test Plan:
- Reset load: reset=1 with cnt_ini=5 mid-count → cnt=5 and timer=0 immediately, without waiting for a clock edge.
- Basic interval: NBITS=8, cnt_ini=0, cnt_rst=10, release reset → timer=1 only in the cycle after the 11th edge; next pulse 11 cycles later.
- Nonzero start: cnt_ini=3, cnt_rst=7 → pulse every 5 cycles; cnt sequence 3,4,5,6,7,3,…
- Degenerate values:
  - cnt_rst=cnt_ini=4 → timer high every cycle.
  - cnt_rst=2, cnt_ini=9 → timer stuck high until reset.
- Mid-count change: cnt_rst=100, at cnt=50 set cnt_rst=20 → timer=1 after the next edge, cnt reloads to cnt_ini.
- Sticky build (TRAFFIC_TIMER_STICKY_EN): cnt_ini=0, cnt_rst=4 → timer rises after edge 5 and stays 1 for 20+ cycles, cnt holds at 4; reset pulse → timer=0, counting restarts.
